// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between fetch and data ports, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN to replace data priority + starvation counter with strict round robin.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t            state_q;
  logic [3:0]        lat_cnt_q;
  logic              owner_q;
  logic              if_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              idle, d_win, i_win;
  assign idle = state_q == IDLE;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q;
  assign d_win = idle && d_req && (!if_req || !last_d_q);
`else
  logic [3:0] starve_cnt_q;
  assign d_win = idle && d_req && (starve_cnt_q < 4'(STARVE_MAX) || !if_req);
`endif
  assign i_win     = idle && if_req && !d_win;
  assign d_gnt     = d_win;
  assign if_gnt    = i_win;
  assign mem_en    = d_win || i_win;
  assign mem_we    = d_win && d_we;
  assign mem_addr  = d_win ? d_addr : i_win ? if_addr : '0;
  assign mem_wdata = d_win ? d_wdata : '0;
  assign busy      = !idle;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      owner_q      <= 1'b0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q     <= 1'b0;
`else
      starve_cnt_q <= '0;
`endif
    end else begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if (idle) begin
        if (mem_en && !mem_we) begin
          state_q   <= WAIT;
          lat_cnt_q <= 4'(MEM_LAT);
          owner_q   <= d_win;
        end
      end else begin
        lat_cnt_q <= lat_cnt_q - 4'd1;
        // last wait cycle: read data is on mem_rdata now
        if (lat_cnt_q == 4'd1) begin
          state_q <= IDLE;
          if (owner_q) begin
            d_rdata_q  <= mem_rdata;
            d_rvalid_q <= 1'b1;
          end else begin
            if_rdata_q  <= mem_rdata;
            if_rvalid_q <= 1'b1;
          end
        end
      end
`ifdef ARB_ROUND_ROBIN_EN
      if (mem_en) last_d_q <= d_win;
`else
      starve_cnt_q <= (!if_req || i_win) ? 4'd0 :
                      (d_win && starve_cnt_q < 4'(STARVE_MAX)) ? starve_cnt_q + 4'd1 : starve_cnt_q;
`endif
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tests of mem_port_arbiter with a 2-cycle latency memory model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:255];
  logic [31:0] p1 = '0, p2 = '0;
  int          n_cmp = 0, n_err = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // memory model: data read at issue appears on mem_rdata two cycles later
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    p1 <= mem[mem_addr[9:2]];
    p2 <= p1;
  end
  assign mem_rdata = p2;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    if_req = 0; d_req = 0; d_we = 0; if_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic test_reset;
    #3;
    n_cmp++;
    if ({if_gnt, d_gnt, mem_en, mem_we, busy, if_rvalid, d_rvalid} !== 7'b0) begin
      n_err++; $display("FAIL reset_flags got %b want 0", {if_gnt, d_gnt, mem_en, mem_we, busy, if_rvalid, d_rvalid});
    end
    n_cmp++;
    if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 128'b0) begin
      n_err++; $display("FAIL reset_data got %h want 0", {if_rdata, d_rdata, mem_addr, mem_wdata});
    end
    @(negedge clk); rst = 0;
    tick;
  endtask

  task automatic test_fetch_read;
    if_req = 1; if_addr = 32'h10; #1;
    n_cmp++;
    if ({if_gnt, d_gnt, mem_en, mem_we, busy, mem_addr} !== {5'b10100, 32'h10}) begin
      n_err++; $display("FAIL fetch_issue got %b_%h want 10100_00000010", {if_gnt, d_gnt, mem_en, mem_we, busy}, mem_addr);
    end
    tick; if_req = 0; #1;
    n_cmp++;
    if ({if_gnt, mem_en, busy, if_rvalid} !== 4'b0010) begin
      n_err++; $display("FAIL fetch_wait1 got %b want 0010", {if_gnt, mem_en, busy, if_rvalid});
    end
    tick;
    n_cmp++;
    if ({busy, if_rvalid} !== 2'b10) begin
      n_err++; $display("FAIL fetch_wait2 got %b want 10", {busy, if_rvalid});
    end
    tick;
    n_cmp++;
    if ({busy, if_rvalid, d_rvalid, if_rdata} !== {3'b010, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL fetch_rvalid got %b_%h want 010_deadbeef", {busy, if_rvalid, d_rvalid}, if_rdata);
    end
    tick;
    n_cmp++;
    if ({if_rvalid, if_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL fetch_pulse got %b_%h want 0_deadbeef", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_dual_read;
    d_req = 1; d_we = 0; d_addr = 32'h40; if_req = 1; if_addr = 32'h80; #1;
    n_cmp++;
    if ({d_gnt, if_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 32'h40}) begin
      n_err++; $display("FAIL dual_d_issue got %b_%h want 1010_00000040", {d_gnt, if_gnt, mem_en, mem_we}, mem_addr);
    end
    tick; d_req = 0; tick; tick;
    n_cmp++;
    if ({d_rvalid, d_rdata, if_gnt, d_gnt, mem_addr} !== {1'b1, 32'h11114040, 2'b10, 32'h80}) begin
      n_err++; $display("FAIL dual_i_issue got %b_%h_%b_%h want 1_11114040_10_00000080", d_rvalid, d_rdata, {if_gnt, d_gnt}, mem_addr);
    end
    tick; if_req = 0; tick; tick;
    n_cmp++;
    if ({if_rvalid, if_rdata, d_rvalid, d_rdata} !== {1'b1, 32'h22228080, 1'b0, 32'h11114040}) begin
      n_err++; $display("FAIL dual_i_rvalid got %b_%h_%b_%h want 1_22228080_0_11114040", if_rvalid, if_rdata, d_rvalid, d_rdata);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h55; #1;
    n_cmp++;
    if ({d_gnt, mem_en, mem_we, busy, mem_addr, mem_wdata} !== {4'b1110, 32'h20, 32'h55}) begin
      n_err++; $display("FAIL wr0 got %b_%h_%h want 1110_00000020_00000055", {d_gnt, mem_en, mem_we, busy}, mem_addr, mem_wdata);
    end
    tick; d_addr = 32'h24; d_wdata = 32'h66; #1;
    n_cmp++;
    if ({d_gnt, mem_en, mem_we, busy, mem_addr, mem_wdata} !== {4'b1110, 32'h24, 32'h66}) begin
      n_err++; $display("FAIL wr1 got %b_%h_%h want 1110_00000024_00000066", {d_gnt, mem_en, mem_we, busy}, mem_addr, mem_wdata);
    end
    tick; idle_inputs; #1;
    n_cmp++;
    if ({d_rvalid, busy, mem[8], mem[9]} !== {2'b00, 32'h55, 32'h66}) begin
      n_err++; $display("FAIL wr_done got %b_%h_%h want 00_00000055_00000066", {d_rvalid, busy}, mem[8], mem[9]);
    end
    tick; tick; tick;
    n_cmp++;
    if (d_rvalid !== 1'b0) begin
      n_err++; $display("FAIL wr_no_rvalid got %b want 0", d_rvalid);
    end
  endtask

`ifndef ARB_ROUND_ROBIN_EN
  task automatic test_starvation;
    logic [1:0] eg [0:8];
    logic [3:0] es [0:8];
    logic       ir [0:8];
    eg = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10};
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 4'd0, 4'd1};
    ir = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'h77; if_addr = 32'h10;
    for (int k = 0; k < 9; k++) begin
      if_req = ir[k]; #1;
      n_cmp++;
      if ({d_gnt, if_gnt, dut.starve_cnt_q} !== {eg[k], es[k]}) begin
        n_err++; $display("FAIL starve_c%0d got gnt=%b cnt=%0d want gnt=%b cnt=%0d", k, {d_gnt, if_gnt}, dut.starve_cnt_q, eg[k], es[k]);
      end
      if (k == 7) begin
        n_cmp++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'hDEADBEEF}) begin
          n_err++; $display("FAIL starve_rvalid got %b_%h want 1_deadbeef", if_rvalid, if_rdata);
        end
      end
      tick;
    end
    idle_inputs; tick;
  endtask
`endif

  task automatic test_reset_mid_wait;
    if_req = 1; if_addr = 32'h10; tick; if_req = 0;
    rst = 1; #1;
    n_cmp++;
    if ({busy, if_gnt, mem_en, if_rvalid, if_rdata} !== 36'b0) begin
      n_err++; $display("FAIL rst_async got %b_%h want 0000_00000000", {busy, if_gnt, mem_en, if_rvalid}, if_rdata);
    end
    tick; rst = 0; tick;
    n_cmp++;
    if ({busy, if_rvalid, d_rvalid, if_rdata} !== 35'b0) begin
      n_err++; $display("FAIL rst_no_rvalid got %b_%h want 000_00000000", {busy, if_rvalid, d_rvalid}, if_rdata);
    end
    tick;
    n_cmp++;
    if (if_rvalid !== 1'b0) begin
      n_err++; $display("FAIL rst_no_rvalid2 got %b want 0", if_rvalid);
    end
    if_req = 1; if_addr = 32'h80; #1;
    n_cmp++;
    if ({if_gnt, mem_en, mem_addr} !== {2'b11, 32'h80}) begin
      n_err++; $display("FAIL rst_regrant got %b_%h want 11_00000080", {if_gnt, mem_en}, mem_addr);
    end
    tick; if_req = 0; tick; tick;
    n_cmp++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h22228080}) begin
      n_err++; $display("FAIL rst_reread got %b_%h want 1_22228080", if_rvalid, if_rdata);
    end
    tick;
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_round_robin;
    logic [1:0] eg [0:5];
    eg = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01};
    rst = 1; tick; rst = 0; tick;
    d_req = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'h99; if_req = 1; if_addr = 32'h10;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++;
      if ({d_gnt, if_gnt} !== eg[k]) begin
        n_err++; $display("FAIL rr_c%0d got %b want %b", k, {d_gnt, if_gnt}, eg[k]);
      end
      tick;
    end
    idle_inputs; tick; tick; tick;
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5000000 + i;
    mem[4] = 32'hDEADBEEF; mem[16] = 32'h11114040; mem[32] = 32'h22228080;
    test_reset;
    test_fetch_read;
    test_dual_read;
    test_back_to_back;
`ifndef ARB_ROUND_ROBIN_EN
    test_starvation;
`endif
    test_reset_mid_wait;
`ifdef ARB_ROUND_ROBIN_EN
    test_round_robin;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
